// File: rtl/div_pkg.sv
// div_pkg: shared state encodings, default sizes and constants for the sequential divider.
package div_pkg;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_FIN} div_state_e;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;
  localparam logic [DIV_WIDTH-1:0] DIVZERO_QUOTIENT = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step, shift in the next dividend bit and trial-subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             quo_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] shift;
  logic [WIDTH:0] diff;
  assign shift = {rem_i, quo_msb_i};
  assign diff  = shift - {1'b0, divisor_i};
  // rem < divisor, so a set top bit of the difference is exactly a borrow
  assign q_o   = ~diff[WIDTH];
  assign rem_o = diff[WIDTH] ? shift[WIDTH-1:0] : diff[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring DIV/DIVU, one quotient bit per clock, Done pulse after WIDTH+1 cycles.
// Define DIV_SIGNED_EN to honour the Signed input; otherwise every operation is unsigned.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);
  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, rem_d;
  logic [WIDTH-1:0] dvd_abs, dvs_abs, quo_fix, rem_fix;
  logic [WIDTH-1:0] quot_q, remd_q;
  logic             qbit_d, dz_q, busy_q, done_q, divzero_q, accept;

  assign accept = (state_q == DIV_IDLE) && Start;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_rem_q;
  assign dvd_abs = (Signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
  assign dvs_abs = (Signed && Divisor[WIDTH-1]) ? -Divisor : Divisor;
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (accept) begin
      neg_quo_q <= Signed & (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
      neg_rem_q <= Signed & Dividend[WIDTH-1];
    end
  end
`else
  logic unused_signed;
  assign unused_signed = Signed;
  assign dvd_abs = Dividend;
  assign dvs_abs = Divisor;
  assign quo_fix = quo_q;
  assign rem_fix = rem_q;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .quo_msb_i(quo_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (rem_d),
    .q_o      (qbit_d)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
      quot_q    <= '0;
      remd_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DIV_IDLE: if (Start) begin
          busy_q    <= 1'b1;
          divzero_q <= 1'b0;
          cnt_q     <= '0;
          rem_q     <= '0;
          dz_q      <= (Divisor == '0);
          // a zero divisor skips iteration; quo_q then carries the raw dividend to Remainder
          quo_q     <= (Divisor == '0) ? Dividend : dvd_abs;
          dvs_q     <= dvs_abs;
          state_q   <= (Divisor == '0) ? DIV_FIN : DIV_RUN;
        end
        DIV_RUN: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[WIDTH-2:0], qbit_d};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= DIV_FIN;
        end
        DIV_FIN: begin
          quot_q    <= dz_q ? WIDTH'(DIVZERO_QUOTIENT) : quo_fix;
          remd_q    <= dz_q ? quo_q : rem_fix;
          divzero_q <= dz_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivZero   = divzero_q;
  assign Quotient  = quot_q;
  assign Remainder = remd_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  logic        Clk, Rst_n, Start, Signed;
  logic [31:0] Dividend, Divisor, Quotient, Remainder;
  logic        Busy, Done, DivZero;
  int          checks = 0;
  int          errors = 0;

  seq_divider dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Signed(Signed),
    .Dividend(Dividend), .Divisor(Divisor), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .Quotient(Quotient), .Remainder(Remainder)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s && SIGNED_EN) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
    end
    return {a / b, a % b};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    Dividend = a;
    Divisor  = b;
    Signed   = s;
    Start    = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc);
    lat      = 0;
    busy_cyc = int'(Busy);
    while (lat < 100) begin
      @(posedge Clk);
      #1 lat++;
      if (Done) break;
      busy_cyc += int'(Busy);
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; Start = 1'b0; Signed = 1'b0; Dividend = '0; Divisor = '0;
    repeat (3) @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", Done); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL rst_divzero: got %b expected 0", DivZero); end
    checks++; if (Quotient !== 32'd0) begin errors++; $display("FAIL rst_q: got %h expected 0", Quotient); end
    checks++; if (Remainder !== 32'd0) begin errors++; $display("FAIL rst_r: got %h expected 0", Remainder); end
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", Busy); end
  endtask

  task automatic test_divu;
    int lat, bc;
    @(negedge Clk);
    start_op(32'd100, 32'd7, 1'b0);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL divu_busy_e0: got %b expected 1", Busy); end
    wait_done(lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected 33", bc); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL divu_busy_done: got %b expected 0", Busy); end
    checks++; if (Quotient !== 32'd14) begin errors++; $display("FAIL divu_q: got %h expected %h", Quotient, 32'd14); end
    checks++; if (Remainder !== 32'd2) begin errors++; $display("FAIL divu_r: got %h expected %h", Remainder, 32'd2); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL divu_dz: got %b expected 0", DivZero); end
    @(posedge Clk); #1;
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL divu_done_pulse: got %b expected 0", Done); end
    checks++; if (Quotient !== 32'd14) begin errors++; $display("FAIL divu_q_hold: got %h expected %h", Quotient, 32'd14); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    @(negedge Clk);
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done(lat, bc);
    checks++; if (Quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_q1: got %h expected ffffffff", Quotient); end
    checks++; if (Remainder !== 32'd0) begin errors++; $display("FAIL b2b_r1: got %h expected 0", Remainder); end
    start_op(32'd10, 32'd3, 1'b0);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b expected 1", Busy); end
    wait_done(lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
    checks++; if (Quotient !== 32'd3) begin errors++; $display("FAIL b2b_q2: got %h expected 3", Quotient); end
    checks++; if (Remainder !== 32'd1) begin errors++; $display("FAIL b2b_r2: got %h expected 1", Remainder); end
  endtask

  task automatic test_divzero;
    int lat, bc;
    @(negedge Clk);
    start_op(32'd55, 32'd0, 1'b0);
    wait_done(lat, bc);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    checks++; if (DivZero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", DivZero); end
    checks++; if (Quotient !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_q: got %h expected ffffffff", Quotient); end
    checks++; if (Remainder !== 32'd55) begin errors++; $display("FAIL dz_r: got %h expected 37", Remainder); end
    @(negedge Clk);
    start_op(32'd9, 32'd4, 1'b0);
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b expected 0", DivZero); end
    wait_done(lat, bc);
    checks++; if (Quotient !== 32'd2) begin errors++; $display("FAIL dz_next_q: got %h expected 2", Quotient); end
  endtask

  task automatic test_signed;
    int lat, bc;
    logic [31:0] eq, er;
    eq = SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC;
    er = SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0001;
    @(negedge Clk);
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(lat, bc);
    checks++; if (Quotient !== eq) begin errors++; $display("FAIL sgn_q: got %h expected %h", Quotient, eq); end
    checks++; if (Remainder !== er) begin errors++; $display("FAIL sgn_r: got %h expected %h", Remainder, er); end
    eq = SIGNED_EN ? 32'h8000_0000 : 32'h0000_0000;
    er = SIGNED_EN ? 32'h0000_0000 : 32'h8000_0000;
    @(negedge Clk);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat, bc);
    checks++; if (Quotient !== eq) begin errors++; $display("FAIL sgn_ovf_q: got %h expected %h", Quotient, eq); end
    checks++; if (Remainder !== er) begin errors++; $display("FAIL sgn_ovf_r: got %h expected %h", Remainder, er); end
  endtask

  task automatic test_ignore_start;
    int lat, bc;
    @(negedge Clk);
    start_op(32'd100, 32'd7, 1'b0);
    repeat (4) @(posedge Clk);
    #1 Dividend = 32'd999; Divisor = 32'd5; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    wait_done(lat, bc);
    checks++; if (lat !== 28) begin errors++; $display("FAIL ign_latency: got %0d expected 28", lat); end
    checks++; if (Quotient !== 32'd14) begin errors++; $display("FAIL ign_q: got %h expected %h", Quotient, 32'd14); end
    checks++; if (Remainder !== 32'd2) begin errors++; $display("FAIL ign_r: got %h expected 2", Remainder); end
    @(posedge Clk); #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart: got %b expected 0", Busy); end
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen;
    @(negedge Clk);
    start_op(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge Clk);
    Rst_n = 1'b0;
    #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", Busy); end
    checks++; if (Quotient !== 32'd0) begin errors++; $display("FAIL rmid_q: got %h expected 0", Quotient); end
    checks++; if (Remainder !== 32'd0) begin errors++; $display("FAIL rmid_r: got %h expected 0", Remainder); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL rmid_dz: got %b expected 0", DivZero); end
    seen = 0;
    repeat (5) begin @(posedge Clk); #1 seen += int'(Done); end
    @(negedge Clk) Rst_n = 1'b1;
    repeat (30) begin @(posedge Clk); #1 seen += int'(Done) + int'(Busy); end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d expected 0", seen); end
    @(negedge Clk);
    start_op(32'd1000, 32'd3, 1'b0);
    wait_done(lat, bc);
    checks++; if (lat !== 33) begin errors++; $display("FAIL rmid_latency: got %0d expected 33", lat); end
    checks++; if (Quotient !== 32'd333) begin errors++; $display("FAIL rmid_q2: got %h expected %h", Quotient, 32'd333); end
    checks++; if (Remainder !== 32'd1) begin errors++; $display("FAIL rmid_r2: got %h expected 1", Remainder); end
  endtask

  task automatic test_random;
    int lat, bc, exp_lat;
    logic [31:0] a, b;
    logic s;
    logic [63:0] e;
    @(negedge Clk);
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0000, 16'($urandom)};
        default: b = $urandom;
      endcase
      if (b == 32'd0 && $urandom_range(0, 1) == 0) b = 32'd1;
      s = 1'($urandom_range(0, 1));
      e = ref_div(a, b, s);
      exp_lat = (b == 32'd0) ? 1 : 33;
      start_op(a, b, s);
      wait_done(lat, bc);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, exp_lat); end
      checks++; if (Quotient !== e[63:32]) begin errors++; $display("FAIL rnd%0d_q: %h/%h s=%b got %h expected %h", i, a, b, s, Quotient, e[63:32]); end
      checks++; if (Remainder !== e[31:0]) begin errors++; $display("FAIL rnd%0d_r: %h/%h s=%b got %h expected %h", i, a, b, s, Remainder, e[31:0]); end
      checks++; if (DivZero !== (b == 32'd0)) begin errors++; $display("FAIL rnd%0d_dz: got %b expected %b", i, DivZero, b == 32'd0); end
      if ($urandom_range(0, 2) == 0) @(negedge Clk);
    end
  endtask

  initial begin
    test_reset;
    test_divu;
    test_back_to_back;
    test_divzero;
    test_signed;
    test_ignore_start;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
